// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings for the MIPS front-end control slice
package mips_ctrl_pkg;

  localparam logic [1:0] S_RUN        = 2'd0;
  localparam logic [1:0] S_FLUSH      = 2'd1;
  localparam logic [1:0] S_WAIT_REDIR = 2'd2;

  // Word the pipeline registers load when told to flush
  localparam logic [31:0] NOP_INSN = 32'h0000_0000;

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// rtl/pc_redirect_ctrl_if.sv - branch/hazard inputs and PC/pipeline-enable outputs
interface pc_redirect_ctrl_if #(
  parameter int CNT_W = 16
);

  logic              BranchValid;
  logic              BranchTaken;
  logic [31:0]       BranchTarget;
  logic              LoadUseHazard;
  logic              IMemReady;

  logic              PCWrite;
  logic              PCSel;
  logic [31:0]       PCTarget;
  logic              IFIDWrite;
  logic              IFIDFlush;
  logic              IDEXFlush;
  logic              Busy;
  logic [CNT_W-1:0]  RedirectCount;

  modport master (
    output BranchValid, BranchTaken, BranchTarget, LoadUseHazard, IMemReady,
    input  PCWrite, PCSel, PCTarget, IFIDWrite, IFIDFlush, IDEXFlush, Busy,
           RedirectCount
  );

  modport slave (
    input  BranchValid, BranchTaken, BranchTarget, LoadUseHazard, IMemReady,
    output PCWrite, PCSel, PCTarget, IFIDWrite, IFIDFlush, IDEXFlush, Busy,
           RedirectCount
  );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - enable-gated up counter that sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;
  logic         w_full;

  assign w_full = (r_count == {W{1'b1}});

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_en && !w_full) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - sequences PC and IF/ID, ID/EX enables for redirects,
// load-use stalls and instruction-memory wait
module pc_redirect_ctrl #(
  parameter int FETCH_LAT = 0,
  parameter int CNT_W     = 16
) (
  input logic               Clk,
  input logic               Reset,
  pc_redirect_ctrl_if.slave bus
);

  import mips_ctrl_pkg::*;

  localparam logic [2:0] LAT = 3'(FETCH_LAT);

  logic [1:0]       r_state;
  logic [2:0]       r_flush_cnt;
  logic [31:0]      r_pending;

  logic             w_redirect;
  logic [1:0]       w_next_state;
  logic [2:0]       w_next_cnt;
  logic [31:0]      w_next_pending;
  logic             w_cnt_en;
  logic [1:0]       w_after_redir;
  logic [CNT_W-1:0] w_count;

  logic             w_pc_write;
  logic             w_pc_sel;
  logic [31:0]      w_pc_target;
  logic             w_ifid_write;
  logic             w_ifid_flush;
  logic             w_idex_flush;
  logic             w_busy;

  assign w_redirect    = bus.BranchValid & bus.BranchTaken;
  // With no fetch latency there are no wrong-path words left to drain
  assign w_after_redir = (LAT == 3'd0) ? S_RUN : S_FLUSH;

  always_comb begin
    w_next_state   = r_state;
    w_next_cnt     = r_flush_cnt;
    w_next_pending = r_pending;
    w_cnt_en       = 1'b0;
    w_pc_write     = 1'b0;
    w_pc_sel       = 1'b0;
    w_pc_target    = 32'h0;
    w_ifid_write   = 1'b1;
    w_ifid_flush   = 1'b0;
    w_idex_flush   = 1'b0;
    w_busy         = (r_state != S_RUN);

    if (Reset) begin
      w_ifid_write = 1'b0;
      w_ifid_flush = 1'b1;
      w_idex_flush = 1'b1;
      w_busy       = 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          w_pc_target = bus.BranchTarget;
          if (w_redirect) begin
            w_pc_sel     = 1'b1;
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
            w_cnt_en     = 1'b1;
            if (bus.IMemReady) begin
              w_pc_write   = 1'b1;
              w_next_state = w_after_redir;
              w_next_cnt   = LAT;
            end else begin
              w_next_pending = bus.BranchTarget;
              w_next_state   = S_WAIT_REDIR;
            end
          end else if (!bus.IMemReady) begin
            w_ifid_flush = 1'b1;
          end else if (bus.LoadUseHazard) begin
            w_ifid_write = 1'b0;
            w_idex_flush = 1'b1;
          end else begin
            w_pc_write = 1'b1;
          end
        end

        S_FLUSH: begin
          // Only bubbles are in ID/EX here, so branch and hazard inputs are don't-care
          w_pc_target  = r_pending;
          w_pc_write   = bus.IMemReady;
          w_ifid_flush = 1'b1;
          if (bus.IMemReady) begin
            if (r_flush_cnt <= 3'd1) begin
              w_next_state = S_RUN;
              w_next_cnt   = 3'd0;
            end else begin
              w_next_cnt = r_flush_cnt - 3'd1;
            end
          end
        end

        S_WAIT_REDIR: begin
          w_pc_target  = r_pending;
          w_pc_sel     = 1'b1;
          w_pc_write   = bus.IMemReady;
          w_ifid_flush = 1'b1;
          w_idex_flush = 1'b1;
          if (bus.IMemReady) begin
            w_next_state = w_after_redir;
            w_next_cnt   = LAT;
          end
        end

        default: begin
          w_next_state = S_RUN;
          w_next_cnt   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= S_RUN;
      r_flush_cnt <= 3'd0;
      r_pending   <= 32'h0;
    end else begin
      r_state     <= w_next_state;
      r_flush_cnt <= w_next_cnt;
      r_pending   <= w_next_pending;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_redirect_cnt (
    .i_clk   (Clk),
    .i_rst   (Reset),
    .i_en    (w_cnt_en),
    .o_count (w_count)
  );

  assign bus.PCWrite       = w_pc_write;
  assign bus.PCSel         = w_pc_sel;
  assign bus.PCTarget      = w_pc_target;
  assign bus.IFIDWrite     = w_ifid_write;
  assign bus.IFIDFlush     = w_ifid_flush;
  assign bus.IDEXFlush     = w_idex_flush;
  assign bus.Busy          = w_busy;
  assign bus.RedirectCount = w_count;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb/tb_pc_redirect_ctrl.sv - vector table and scoreboard bench for pc_redirect_ctrl
module tb_pc_redirect_ctrl;

  typedef struct {
    string       name;
    bit          rst;
    bit          bv;
    bit          bt;
    logic [31:0] tgt;
    bit          lu;
    bit          rdy;
    bit          pw;
    bit          ps;
    logic [31:0] pt;
    bit          iw;
    bit          ifl;
    bit          idf;
    bit          bz;
    logic [3:0]  rc;
  } vec_t;

  logic Clk;
  logic Reset;
  int   n_cmp;
  int   n_fail;
  vec_t tbl[$];
  vec_t exp_q[$];
  logic [3:0] rc_model;

  pc_redirect_ctrl_if #(.CNT_W(4)) bus ();

  pc_redirect_ctrl #(
    .FETCH_LAT (2),
    .CNT_W     (4)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic vec_t mk(string n, bit r, bit bv, bit bt, logic [31:0] tg,
                              bit lu, bit rdy, bit pw, bit ps, logic [31:0] pt,
                              bit iw, bit ifl, bit idf, bit bz, logic [3:0] rc);
    vec_t v;
    v.name = n; v.rst = r; v.bv = bv; v.bt = bt; v.tgt = tg; v.lu = lu; v.rdy = rdy;
    v.pw = pw; v.ps = ps; v.pt = pt; v.iw = iw; v.ifl = ifl; v.idf = idf; v.bz = bz;
    v.rc = rc;
    return v;
  endfunction

  task automatic chk(string step, string field, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", step, field, act, exp);
    end
  endtask

  task automatic apply(vec_t v);
    vec_t e;
    @(negedge Clk);
    Reset             = v.rst;
    bus.BranchValid   = v.bv;
    bus.BranchTaken   = v.bt;
    bus.BranchTarget  = v.tgt;
    bus.LoadUseHazard = v.lu;
    bus.IMemReady     = v.rdy;
    exp_q.push_back(v);
    #1;
    e = exp_q.pop_front();
    chk(e.name, "PCWrite",       32'(bus.PCWrite),       32'(e.pw));
    chk(e.name, "PCSel",         32'(bus.PCSel),         32'(e.ps));
    if (e.ps || e.rst)
      chk(e.name, "PCTarget",    bus.PCTarget,           e.pt);
    chk(e.name, "IFIDWrite",     32'(bus.IFIDWrite),     32'(e.iw));
    chk(e.name, "IFIDFlush",     32'(bus.IFIDFlush),     32'(e.ifl));
    chk(e.name, "IDEXFlush",     32'(bus.IDEXFlush),     32'(e.idf));
    chk(e.name, "Busy",          32'(bus.Busy),          32'(e.bz));
    chk(e.name, "RedirectCount", 32'(bus.RedirectCount), 32'(e.rc));
  endtask

  // Taken branch accepted with IMem ready, followed by its two drain cycles
  task automatic redirect_and_drain(logic [31:0] tg);
    apply(mk("sat_redir", 0, 1, 1, tg, 0, 1, 1, 1, tg, 1, 1, 1, 0, rc_model));
    if (rc_model != 4'hF) rc_model = rc_model + 4'd1;
    apply(mk("sat_flush1", 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 1, rc_model));
    apply(mk("sat_flush2", 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 1, rc_model));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    Reset             = 1'b1;
    bus.BranchValid   = 1'b0;
    bus.BranchTaken   = 1'b0;
    bus.BranchTarget  = 32'h0;
    bus.LoadUseHazard = 1'b0;
    bus.IMemReady     = 1'b1;

    //             name             r bv bt tgt           lu rdy pw ps pt           iw if id bz rc
    tbl.push_back(mk("rst0",          1, 0, 0, 32'h0,       0, 1,  0, 0, 32'h0,       0, 1, 1, 0, 0));
    tbl.push_back(mk("rst1_redir",    1, 1, 1, 32'h44,      1, 1,  0, 0, 32'h0,       0, 1, 1, 0, 0));
    tbl.push_back(mk("run",           0, 0, 0, 32'h0,       0, 1,  1, 0, 32'h0,       1, 0, 0, 0, 0));
    tbl.push_back(mk("not_taken",     0, 1, 0, 32'hdead,    0, 1,  1, 0, 32'h0,       1, 0, 0, 0, 0));
    tbl.push_back(mk("taken_noval",   0, 0, 1, 32'hbeef,    0, 1,  1, 0, 32'h0,       1, 0, 0, 0, 0));
    tbl.push_back(mk("redir40",       0, 1, 1, 32'h40,      0, 1,  1, 1, 32'h40,      1, 1, 1, 0, 0));
    tbl.push_back(mk("flush_a_ign",   0, 1, 1, 32'h80,      1, 1,  1, 0, 32'h0,       1, 1, 0, 1, 1));
    tbl.push_back(mk("flush_b",       0, 0, 0, 32'h0,       0, 1,  1, 0, 32'h0,       1, 1, 0, 1, 1));
    tbl.push_back(mk("run_after40",   0, 0, 0, 32'h0,       0, 1,  1, 0, 32'h0,       1, 0, 0, 0, 1));
    tbl.push_back(mk("redir100_nrdy", 0, 1, 1, 32'h100,     0, 0,  0, 1, 32'h100,     1, 1, 1, 0, 1));
    tbl.push_back(mk("wait1",         0, 0, 0, 32'h0,       0, 0,  0, 1, 32'h100,     1, 1, 1, 1, 2));
    tbl.push_back(mk("wait2_newbr",   0, 1, 1, 32'h200,     0, 0,  0, 1, 32'h100,     1, 1, 1, 1, 2));
    tbl.push_back(mk("wait3",         0, 0, 0, 32'h0,       0, 0,  0, 1, 32'h100,     1, 1, 1, 1, 2));
    tbl.push_back(mk("wait_ready",    0, 0, 0, 32'h0,       0, 1,  1, 1, 32'h100,     1, 1, 1, 1, 2));
    tbl.push_back(mk("flush_c",       0, 0, 0, 32'h0,       0, 1,  1, 0, 32'h0,       1, 1, 0, 1, 2));
    tbl.push_back(mk("flush_stall",   0, 0, 0, 32'h0,       0, 0,  0, 0, 32'h0,       1, 1, 0, 1, 2));
    tbl.push_back(mk("flush_d",       0, 0, 0, 32'h0,       0, 1,  1, 0, 32'h0,       1, 1, 0, 1, 2));
    tbl.push_back(mk("run2",          0, 0, 0, 32'h0,       0, 1,  1, 0, 32'h0,       1, 0, 0, 0, 2));
    tbl.push_back(mk("loaduse",       0, 0, 0, 32'h0,       1, 1,  0, 0, 32'h0,       0, 0, 1, 0, 2));
    tbl.push_back(mk("run3",          0, 0, 0, 32'h0,       0, 1,  1, 0, 32'h0,       1, 0, 0, 0, 2));
    tbl.push_back(mk("lu_hold1",      0, 0, 0, 32'h0,       1, 1,  0, 0, 32'h0,       0, 0, 1, 0, 2));
    tbl.push_back(mk("lu_hold2",      0, 0, 0, 32'h0,       1, 1,  0, 0, 32'h0,       0, 0, 1, 0, 2));
    tbl.push_back(mk("run4",          0, 0, 0, 32'h0,       0, 1,  1, 0, 32'h0,       1, 0, 0, 0, 2));
    tbl.push_back(mk("imem_wait",     0, 0, 0, 32'h0,       0, 0,  0, 0, 32'h0,       1, 1, 0, 0, 2));
    tbl.push_back(mk("imem_wait_lu",  0, 0, 0, 32'h0,       1, 0,  0, 0, 32'h0,       1, 1, 0, 0, 2));
    tbl.push_back(mk("redir_lu300",   0, 1, 1, 32'h300,     1, 1,  1, 1, 32'h300,     1, 1, 1, 0, 2));
    tbl.push_back(mk("flush_e_lu",    0, 0, 0, 32'h0,       1, 1,  1, 0, 32'h0,       1, 1, 0, 1, 3));
    tbl.push_back(mk("flush_f",       0, 0, 0, 32'h0,       0, 1,  1, 0, 32'h0,       1, 1, 0, 1, 3));
    tbl.push_back(mk("run5",          0, 0, 0, 32'h0,       0, 1,  1, 0, 32'h0,       1, 0, 0, 0, 3));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    rc_model = 4'd3;
    for (int i = 0; i < 17; i++) redirect_and_drain(32'h1000 + 32'(i) * 32'h10);
    apply(mk("sat_hold", 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 4'hF));

    apply(mk("rf_redir",  0, 1, 1, 32'h400, 0, 1, 1, 1, 32'h400, 1, 1, 1, 0, 4'hF));
    apply(mk("rf_flush",  0, 0, 0, 32'h0,   0, 1, 1, 0, 32'h0,   1, 1, 0, 1, 4'hF));
    apply(mk("rf_reset",  1, 0, 0, 32'h0,   0, 1, 0, 0, 32'h0,   0, 1, 1, 0, 4'hF));
    apply(mk("rf_run",    0, 0, 0, 32'h0,   0, 1, 1, 0, 32'h0,   1, 0, 0, 0, 4'h0));

    apply(mk("rw_redir",  0, 1, 1, 32'h500, 0, 0, 0, 1, 32'h500, 1, 1, 1, 0, 4'h0));
    apply(mk("rw_wait",   0, 0, 0, 32'h0,   0, 0, 0, 1, 32'h500, 1, 1, 1, 1, 4'h1));
    apply(mk("rw_reset",  1, 0, 0, 32'h0,   0, 0, 0, 0, 32'h0,   0, 1, 1, 0, 4'h1));
    apply(mk("rw_run",    0, 0, 0, 32'h0,   0, 1, 1, 0, 32'h0,   1, 0, 0, 0, 4'h0));
    apply(mk("rw_redir2", 0, 1, 1, 32'h600, 0, 0, 0, 1, 32'h600, 1, 1, 1, 0, 4'h0));
    apply(mk("rw_wait2",  0, 0, 0, 32'h0,   0, 0, 0, 1, 32'h600, 1, 1, 1, 1, 4'h1));
    apply(mk("rw_go",     0, 0, 0, 32'h0,   0, 1, 1, 1, 32'h600, 1, 1, 1, 1, 4'h1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
